// File: rtl/xif_issue_tracker_if.sv
// xif_issue_tracker_if: snooped CV-X-IF handshakes plus tracker event/counter/error outputs
interface xif_issue_tracker_if #(
  parameter int X_ID_WIDTH = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int LAT_WIDTH  = 16
);
  logic                      issue_valid_i;
  logic                      issue_ready_i;
  logic                      issue_accept_i;
  logic [X_ID_WIDTH-1:0]     issue_id_i;
  logic [31:0]               issue_instr_i;
  logic                      commit_valid_i;
  logic [X_ID_WIDTH-1:0]     commit_id_i;
  logic                      commit_kill_i;
  logic                      result_valid_i;
  logic                      result_ready_i;
  logic [X_ID_WIDTH-1:0]     result_id_i;
  logic                      evt_valid_o;
  logic                      evt_ready_i;
  logic [X_ID_WIDTH-1:0]     evt_id_o;
  logic [LAT_WIDTH-1:0]      evt_lat_o;
  logic [2**X_ID_WIDTH-1:0]  outstanding_o;
  logic [CNT_WIDTH-1:0]      cnt_accept_o;
  logic [CNT_WIDTH-1:0]      cnt_reject_o;
  logic [CNT_WIDTH-1:0]      cnt_stall_o;
  logic [CNT_WIDTH-1:0]      cnt_kill_o;
  logic [CNT_WIDTH-1:0]      cnt_drop_o;
  logic [5:0]                err_o;
  modport master (
    output issue_valid_i, issue_ready_i, issue_accept_i, issue_id_i, issue_instr_i,
           commit_valid_i, commit_id_i, commit_kill_i,
           result_valid_i, result_ready_i, result_id_i, evt_ready_i,
    input  evt_valid_o, evt_id_o, evt_lat_o, outstanding_o,
           cnt_accept_o, cnt_reject_o, cnt_stall_o, cnt_kill_o, cnt_drop_o, err_o
  );
  modport slave (
    input  issue_valid_i, issue_ready_i, issue_accept_i, issue_id_i, issue_instr_i,
           commit_valid_i, commit_id_i, commit_kill_i,
           result_valid_i, result_ready_i, result_id_i, evt_ready_i,
    output evt_valid_o, evt_id_o, evt_lat_o, outstanding_o,
           cnt_accept_o, cnt_reject_o, cnt_stall_o, cnt_kill_o, cnt_drop_o, err_o
  );
endinterface

// File: rtl/xif_issue_tracker.sv
// xif_issue_tracker: per-ID scoreboard, latency, protocol checks and event FIFO for CV-X-IF
module xif_issue_tracker #(
  parameter int X_ID_WIDTH = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int LAT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input logic clk_i,
  input logic rst_i,
  input logic clear_i,
  xif_issue_tracker_if.slave x
);
  localparam int N  = 2**X_ID_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [N-1:0] r_out, r_com, w_out, w_com;
  logic [LAT_WIDTH-1:0] r_lat [N];
  logic [LAT_WIDTH-1:0] w_lat [N];
  logic [X_ID_WIDTH+LAT_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0] r_cnt;
  logic r_stall_q;
  logic [X_ID_WIDTH-1:0] r_id_q;
  logic [31:0] r_instr_q;
  logic [5:0] r_err, w_err;
  logic [CNT_WIDTH-1:0] r_acc, r_rej, r_stall, r_kill, r_drop;
  logic w_ih, w_stall, w_rh, w_load, w_kill, w_push, w_dup, w_pop, w_drop, w_wr;
  function automatic logic [CNT_WIDTH-1:0] inc(input logic [CNT_WIDTH-1:0] v, input logic e);
    return v + CNT_WIDTH'(e & ~&v);
  endfunction
  // Commit, then result, then issue act on a working copy of the scoreboard.
  always_comb begin
    w_ih = x.issue_valid_i & x.issue_ready_i;
    w_stall = x.issue_valid_i & ~x.issue_ready_i;
    w_rh = x.result_valid_i & x.result_ready_i;
    w_load = w_ih & x.issue_accept_i;
    w_kill = x.commit_valid_i & x.commit_kill_i & r_out[x.commit_id_i];
    w_out = r_out;
    w_com = r_com;
    if (x.commit_valid_i & r_out[x.commit_id_i]) begin
      w_out[x.commit_id_i] = ~x.commit_kill_i;
      w_com[x.commit_id_i] = ~x.commit_kill_i | r_com[x.commit_id_i];
    end
    w_push = w_rh & w_out[x.result_id_i] & w_com[x.result_id_i];
    if (w_push) w_out[x.result_id_i] = 1'b0;
    w_dup = w_load & w_out[x.issue_id_i];
    if (w_load) begin
      w_out[x.issue_id_i] = 1'b1;
      w_com[x.issue_id_i] = 1'b0;
    end
    for (int i = 0; i < N; i++)
      w_lat[i] = (w_load && x.issue_id_i == X_ID_WIDTH'(i)) ? LAT_WIDTH'(1) :
                 (r_out[i] && !(w_push && x.result_id_i == X_ID_WIDTH'(i)) && !(&r_lat[i])) ?
                 r_lat[i] + LAT_WIDTH'(1) : r_lat[i];
    w_pop = (r_cnt != '0) & x.evt_ready_i;
    w_drop = w_push & (r_cnt == (PW+1)'(FIFO_DEPTH)) & ~w_pop;
    w_wr = w_push & ~w_drop;
    w_err = {w_drop, w_rh & ~w_push, x.commit_valid_i & ~r_out[x.commit_id_i], w_dup,
             r_stall_q & x.issue_valid_i & (x.issue_instr_i != r_instr_q || x.issue_id_i != r_id_q),
             r_stall_q & ~x.issue_valid_i};
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out <= '0;
      r_com <= '0;
      for (int i = 0; i < N; i++) r_lat[i] <= '0;
      r_stall_q <= 1'b0;
      r_id_q <= '0;
      r_instr_q <= '0;
    end else begin
      r_out <= w_out;
      r_com <= w_com;
      for (int i = 0; i < N; i++) r_lat[i] <= w_lat[i];
      r_stall_q <= w_stall;
      r_id_q <= x.issue_id_i;
      r_instr_q <= x.issue_instr_i;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || clear_i) begin
      {r_acc, r_rej, r_stall, r_kill, r_drop} <= '0;
      r_err <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_acc <= inc(r_acc, w_load);
      r_rej <= inc(r_rej, w_ih & ~x.issue_accept_i);
      r_stall <= inc(r_stall, w_stall);
      r_kill <= inc(r_kill, w_kill);
      r_drop <= inc(r_drop, w_drop);
      r_err <= r_err | w_err;
      r_wp <= r_wp + PW'(w_wr);
      r_rp <= r_rp + PW'(w_pop);
      r_cnt <= r_cnt + (PW+1)'(w_wr) - (PW+1)'(w_pop);
    end
  end
  // Latency captured is the pre-increment value, i.e. edges elapsed since issue.
  always_ff @(posedge clk_i)
    if (w_wr && !clear_i) r_mem[r_wp] <= {x.result_id_i, r_lat[x.result_id_i]};
  assign x.evt_valid_o = r_cnt != '0;
  assign {x.evt_id_o, x.evt_lat_o} = x.evt_valid_o ? r_mem[r_rp] : '0;
  assign x.outstanding_o = r_out;
  assign x.err_o = r_err;
  assign x.cnt_accept_o = r_acc;
  assign x.cnt_reject_o = r_rej;
  assign x.cnt_stall_o = r_stall;
  assign x.cnt_kill_o = r_kill;
  assign x.cnt_drop_o = r_drop;
endmodule

// File: tb/tb_xif_issue_tracker.sv
// tb_xif_issue_tracker: directed plus random checks of xif_issue_tracker against a timestamp/queue model
module tb_xif_issue_tracker;
  localparam int IW = 4, CW = 32, LW = 4, D = 8, N = 16;
  logic clk = 0, rst = 1, clr = 0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  xif_issue_tracker_if #(.X_ID_WIDTH(IW), .CNT_WIDTH(CW), .LAT_WIDTH(LW)) x();
  xif_issue_tracker #(.X_ID_WIDTH(IW), .CNT_WIDTH(CW), .LAT_WIDTH(LW), .FIFO_DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .x(x)
  );
  bit m_out [N];
  bit m_com [N];
  int m_t [N];
  int cyc;
  int m_q [$];
  bit [5:0] m_err;
  longint m_acc, m_rej, m_stall, m_kill, m_drop;
  bit p_stall;
  bit [IW-1:0] p_id;
  bit [31:0] p_instr;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", n, a, e, $time);
    end
  endtask
  // Model: latency is the difference of issue and result edge timestamps.
  initial begin
    bit [5:0] e;
    bit popped, push;
    int ev, lat;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        foreach (m_out[i]) begin m_out[i] = 0; m_com[i] = 0; m_t[i] = 0; end
        m_q.delete();
        m_err = 0; m_acc = 0; m_rej = 0; m_stall = 0; m_kill = 0; m_drop = 0;
        p_stall = 0; p_id = 0; p_instr = 0; cyc = 0;
      end else begin
        cyc++; e = 0; push = 0; ev = 0;
        if (x.commit_valid_i) begin
          if (!m_out[x.commit_id_i]) e[3] = 1;
          else if (x.commit_kill_i) begin m_out[x.commit_id_i] = 0; m_kill++; end
          else m_com[x.commit_id_i] = 1;
        end
        if (x.result_valid_i && x.result_ready_i) begin
          if (m_out[x.result_id_i] && m_com[x.result_id_i]) begin
            m_out[x.result_id_i] = 0;
            lat = cyc - m_t[x.result_id_i];
            if (lat > 2**LW - 1) lat = 2**LW - 1;
            push = 1; ev = (int'(x.result_id_i) << LW) | lat;
          end else e[4] = 1;
        end
        if (x.issue_valid_i && x.issue_ready_i) begin
          if (x.issue_accept_i) begin
            if (m_out[x.issue_id_i]) e[2] = 1;
            m_out[x.issue_id_i] = 1; m_com[x.issue_id_i] = 0; m_t[x.issue_id_i] = cyc; m_acc++;
          end else m_rej++;
        end
        if (x.issue_valid_i && !x.issue_ready_i) m_stall++;
        if (p_stall && !x.issue_valid_i) e[0] = 1;
        if (p_stall && x.issue_valid_i && (p_id != x.issue_id_i || p_instr != x.issue_instr_i)) e[1] = 1;
        p_stall = x.issue_valid_i && !x.issue_ready_i; p_id = x.issue_id_i; p_instr = x.issue_instr_i;
        popped = m_q.size() > 0 && x.evt_ready_i;
        if (push && m_q.size() == D && !popped) begin e[5] = 1; m_drop++; push = 0; end
        if (popped) void'(m_q.pop_front());
        if (push) m_q.push_back(ev);
        if (clr) begin
          m_q.delete(); m_err = 0; m_acc = 0; m_rej = 0; m_stall = 0; m_kill = 0; m_drop = 0;
        end else m_err |= e;
      end
    end
  end
  always @(negedge clk) begin
    logic [N-1:0] ov;
    foreach (m_out[i]) ov[i] = m_out[i];
    chk("evt_valid", x.evt_valid_o, m_q.size() > 0);
    if (m_q.size() > 0) chk("evt_head", {x.evt_id_o, x.evt_lat_o}, m_q[0]);
    chk("outstanding", x.outstanding_o, ov);
    chk("err", x.err_o, m_err);
    chk("cnt_accept", x.cnt_accept_o, m_acc[CW-1:0]);
    chk("cnt_reject", x.cnt_reject_o, m_rej[CW-1:0]);
    chk("cnt_stall", x.cnt_stall_o, m_stall[CW-1:0]);
    chk("cnt_kill", x.cnt_kill_o, m_kill[CW-1:0]);
    chk("cnt_drop", x.cnt_drop_o, m_drop[CW-1:0]);
  end
  task automatic nx();
    @(negedge clk);
  endtask
  task automatic idle();
    x.issue_valid_i = 0; x.issue_ready_i = 0; x.issue_accept_i = 0; x.issue_id_i = 0; x.issue_instr_i = 0;
    x.commit_valid_i = 0; x.commit_id_i = 0; x.commit_kill_i = 0;
    x.result_valid_i = 0; x.result_ready_i = 0; x.result_id_i = 0; clr = 0;
  endtask
  task automatic ih(input int id, input bit acc);
    x.issue_valid_i = 1; x.issue_ready_i = 1; x.issue_accept_i = acc;
    x.issue_id_i = IW'(id); x.issue_instr_i = 32'h13 + 32'(id);
  endtask
  task automatic cm(input int id, input bit kill);
    x.commit_valid_i = 1; x.commit_id_i = IW'(id); x.commit_kill_i = kill;
  endtask
  task automatic rh(input int id);
    x.result_valid_i = 1; x.result_ready_i = 1; x.result_id_i = IW'(id);
  endtask
  initial begin
    bit st;
    idle(); x.evt_ready_i = 0;
    nx(); nx();
    chk("reset_valid", x.evt_valid_o, 0);
    chk("reset_err", x.err_o, 0);
    chk("reset_out", x.outstanding_o, 0);
    rst = 0;
    nx();
    ih(3, 1); nx(); idle(); nx(); cm(3, 0); nx(); idle(); nx(); nx(); rh(3); nx(); idle();
    chk("basic_valid", x.evt_valid_o, 1);
    chk("basic_id", x.evt_id_o, 3);
    chk("basic_lat", x.evt_lat_o, 5);
    chk("basic_acc", x.cnt_accept_o, 1);
    chk("basic_out", x.outstanding_o, 0);
    x.evt_ready_i = 1; nx(); x.evt_ready_i = 0;
    chk("basic_pop", x.evt_valid_o, 0);
    x.issue_valid_i = 1; x.issue_ready_i = 0; x.issue_id_i = 1; x.issue_instr_i = 32'hAAAA;
    repeat (4) nx();
    x.issue_instr_i = 32'hBBBB; x.issue_ready_i = 1; x.issue_accept_i = 1; nx(); idle();
    chk("stall_cnt", x.cnt_stall_o, 4);
    chk("stall_err1", x.err_o, 6'b000010);
    clr = 1; nx(); idle();
    chk("clear_err", x.err_o, 0);
    chk("clear_cnt", x.cnt_stall_o, 0);
    chk("clear_out", x.outstanding_o, 16'h0002);
    x.issue_valid_i = 1; x.issue_id_i = 1; x.issue_instr_i = 32'hAAAA; nx(); idle(); nx();
    chk("drop_err0", x.err_o, 6'b000001);
    ih(5, 1); nx(); idle(); cm(5, 1); nx(); idle();
    chk("kill_cnt", x.cnt_kill_o, 1);
    chk("kill_noevt", x.evt_valid_o, 0);
    rh(5); nx(); idle(); cm(9, 0); nx(); idle();
    chk("unknown_err", x.err_o, 6'b011001);
    clr = 1; nx(); idle();
    ih(2, 1); nx(); idle(); cm(2, 0); nx(); idle(); rh(2); ih(2, 1); nx(); idle();
    chk("same_valid", x.evt_valid_o, 1);
    chk("same_id", x.evt_id_o, 2);
    chk("same_out2", x.outstanding_o[2], 1);
    chk("same_err2", x.err_o[2], 0);
    x.evt_ready_i = 1; ih(2, 1); nx(); idle(); x.evt_ready_i = 0;
    chk("reuse_err2", x.err_o[2], 1);
    clr = 1; nx(); idle();
    for (int k = 0; k < 9; k++) begin
      ih(6 + k, 1); nx(); idle(); cm(6 + k, 0); rh(6 + k); nx(); idle();
    end
    chk("ovf_drop", x.cnt_drop_o, 1);
    chk("ovf_err5", x.err_o[5], 1);
    x.evt_ready_i = 1;
    for (int k = 0; k < 8; k++) begin
      chk("ovf_order", {x.evt_id_o, x.evt_lat_o}, {4'(6 + k), 4'd1});
      nx();
    end
    x.evt_ready_i = 0;
    chk("ovf_empty", x.evt_valid_o, 0);
    ih(15, 1); nx(); idle(); cm(15, 0); nx(); idle(); repeat (18) nx(); rh(15); nx(); idle();
    chk("sat_lat", x.evt_lat_o, 15);
    x.evt_ready_i = 1; nx();
    st = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!(st && $urandom_range(9) != 0)) begin
        x.issue_valid_i = 1'($urandom); x.issue_id_i = IW'($urandom_range(5)); x.issue_instr_i = $urandom;
      end
      x.issue_ready_i = 1'($urandom); x.issue_accept_i = $urandom_range(3) != 0;
      x.commit_valid_i = $urandom_range(2) == 0; x.commit_id_i = IW'($urandom_range(5));
      x.commit_kill_i = $urandom_range(4) == 0;
      x.result_valid_i = $urandom_range(2) == 0; x.result_ready_i = $urandom_range(3) != 0;
      x.result_id_i = IW'($urandom_range(5));
      x.evt_ready_i = 1'($urandom); clr = $urandom_range(299) == 0;
      st = x.issue_valid_i && !x.issue_ready_i;
      nx();
    end
    idle(); x.evt_ready_i = 0;
    ih(3, 1); nx(); idle();
    #2 rst = 1;
    #1;
    chk("arst_out", x.outstanding_o, 0);
    chk("arst_valid", x.evt_valid_o, 0);
    chk("arst_acc", x.cnt_accept_o, 0);
    chk("arst_err", x.err_o, 0);
    nx(); rst = 0; nx(); nx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/xif_issue_tracker.md
# xif_issue_tracker

Synthesizable, parametrised transaction tracker for the CV-X-IF offload path, placed between the core and the coprocessor alongside the issue/commit/result channels. It snoops the issue, commit and result handshakes without driving them. It keeps a per-ID scoreboard of outstanding instructions, measures issue-to-result latency per ID, and checks handshake protocol rules with sticky error flags. Completed transactions are delivered through a poppable event FIFO, and performance counters are exposed, for on-chip debug and for the testbench.

## Interface
- X_ID_WIDTH, 4: width of instruction ID; scoreboard has 2**X_ID_WIDTH entries.
- CNT_WIDTH, 32: width of each performance counter.
- LAT_WIDTH, 16: width of per-ID latency counter.
- FIFO_DEPTH, 8: event FIFO entries; power of two, at least 2.

- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  asynchronous, active-high reset.
- clear_i  in  1  synchronous clear of counters, sticky errors and FIFO.
- issue_valid_i  in  1  snooped issue valid.
- issue_ready_i  in  1  snooped issue ready.
- issue_accept_i  in  1  snooped issue_resp.accept.
- issue_id_i  in  X_ID_WIDTH  snooped issue_req.id.
- issue_instr_i  in  32  snooped issue_req.instr.
- commit_valid_i  in  1  snooped commit valid.
- commit_id_i  in  X_ID_WIDTH  commit ID.
- commit_kill_i  in  1  commit_kill.
- result_valid_i  in  1  snooped result valid.
- result_ready_i  in  1  snooped result ready.
- result_id_i  in  X_ID_WIDTH  result ID.
- evt_valid_o  out  1  FIFO head valid.
- evt_ready_i  in  1  FIFO pop.
- evt_id_o  out  X_ID_WIDTH  retired ID.
- evt_lat_o  out  LAT_WIDTH  issue-to-result latency in cycles.
- outstanding_o  out  2**X_ID_WIDTH  scoreboard valid bits.
- cnt_accept_o, cnt_reject_o, cnt_stall_o, cnt_kill_o, cnt_drop_o  out  CNT_WIDTH each  performance counters.
- err_o  out  6  sticky errors: [0] valid_drop, [1] req_change, [2] id_reuse, [3] commit_unknown, [4] result_unknown, [5] fifo_overflow.

## Operation
- **Handshake definitions.**
  - Issue handshake (IH): issue_valid_i & issue_ready_i.
  - Stall: issue_valid_i & !issue_ready_i.
  - Result handshake (RH): result_valid_i & result_ready_i.
- **Scoreboard.** Each entry holds outstanding, committed and lat[LAT_WIDTH].
- **IH with accept.**
  - Set outstanding, clear committed, load lat to 1.
  - If the entry was already outstanding, set err[2]; the entry is still reloaded.
- **IH without accept.** No scoreboard change.
- **Latency counting.** Each cycle, every outstanding entry not loaded or retired that cycle increments lat, saturating at all-ones.
- **Commit** (commit_valid_i), applied to entry commit_id_i:
  - Entry not outstanding: set err[3], no state change.
  - kill=0: set committed.
  - kill=1: clear outstanding, no FIFO event.
- **RH** on result_id_i:
  - Entry outstanding & committed: clear outstanding, push {id, lat} to FIFO.
  - Otherwise: set err[4], no push.
- **Processing order within one cycle:** commit → result → issue.
  - Commit and RH on the same ID: the result retires normally. If that commit is a kill, the entry is cleared first and the RH flags err[4].
  - RH and accepted IH on the same ID: the retire happens first, then the new issue loads. No err[2].
- **Protocol checks** use registered previous-cycle values.
  - Stall in cycle N and issue_valid_i=0 in N+1: set err[0].
  - Stall in cycle N, issue_valid_i=1 in N+1, and issue_instr_i or issue_id_i differs: set err[1].
- **FIFO.**
  - Push when full without a simultaneous pop: drop the event, set err[5], increment cnt_drop.
  - Push and pop together when full: both happen.
- **Counters.** All saturate at all-ones.
  - cnt_accept: IH&accept.
  - cnt_reject: IH&!accept.
  - cnt_stall: stall cycles.
  - cnt_kill: valid killing commits.
  - cnt_drop: dropped events.
- **clear_i.**
  - Zeroes counters, err_o and FIFO.
  - Does not touch the scoreboard.
  - Events in the same cycle are discarded (clear wins).

## Timing
- **Reset:** every output is 0, all scoreboard entries are invalid, and the FIFO is empty.
- **Latency of state updates:** all outputs are registered. Counters, err_o and outstanding_o reflect an event on the edge that samples it, i.e. visible in the following cycle.
- **FIFO event timing:**
  - An RH at edge E makes evt_valid_o=1 from E onward if the FIFO was empty.
  - evt_id_o/evt_lat_o are stable while evt_valid_o & !evt_ready_i.
  - A pop occurs on an edge with evt_valid_o & evt_ready_i.
- **Latency value:** RH one cycle after IH gives evt_lat_o=1. Back-to-back IH/RH gap of k cycles gives k, saturating at 2**LAT_WIDTH-1.
- **Reset mid-operation:** asynchronous reset immediately clears all state; in-flight IDs are forgotten.

## Test plan
- **Basic retire:** IH id=3 accept at cycle 10, commit id=3 kill=0 at 12, RH id=3 at 15 → evt_id_o=3, evt_lat_o=5, cnt_accept_o=1, outstanding_o=0.
- **Stall and protocol errors:**
  - Stall 4 cycles, then instr changes while stalled → cnt_stall_o=4, err_o[1]=1.
  - Separate run: valid deasserted after a stall → err_o[0]=1.
- **Kill and unknowns:**
  - IH id=5, commit id=5 kill=1 → no event, cnt_kill_o=1.
  - Later RH id=5 → err_o[4]=1.
  - Commit id=9 never issued → err_o[3]=1.
- **Same-cycle ordering:**
  - RH id=2 and accepted IH id=2 in the same cycle → one event, outstanding_o[2]=1, err_o[2]=0.
  - Accepted IH id=2 again while outstanding → err_o[2]=1.
- **FIFO overflow:** evt_ready_i=0, retire 9 transactions with FIFO_DEPTH=8 → 8 events held, cnt_drop_o=1, err_o[5]=1. Pop all → IDs in retire order.
- **Saturation/clear/reset:**
  - LAT_WIDTH=4, RH 20 cycles after IH → evt_lat_o=15.
  - clear_i → counters and err_o zero, outstanding_o unchanged.
  - rst_i asserted mid-transaction → all outputs 0 asynchronously.
